fp_max_abs_reduce: RTL and testbench

FP_MAX_ABS_REDUCE -- requirements
Module: fp_max_abs_reduce

---
 rtl/fp_max_abs_reduce_pkg.sv | 34 +++
 rtl/fp_max_abs_reduce_if.sv | 36 +++
 rtl/fp_max_abs_reduce_mag_cmp.sv | 20 ++
 rtl/fp_max_abs_reduce.sv | 108 ++++++++++
 tb/tb_fp_max_abs_reduce.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_max_abs_reduce_pkg.sv
// Shared float helpers and frame-state encoding for the reduction blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fp_max_abs_reduce_pkg;

    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 10;
    localparam int DEF_IDX_W = 8;
    localparam int FP_MAX_W  = 64;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_e;

    // Operands are zero-extended to FP_MAX_W so one function serves every format.
    function automatic logic fp_is_nan(input logic [FP_MAX_W-1:0] bits,
                                       input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] man_mask;
        logic [FP_MAX_W-1:0] exp_mask;
        man_mask = (64'd1 << man_w) - 64'd1;
        exp_mask = ((64'd1 << exp_w) - 64'd1) << man_w;
        return ((bits & exp_mask) == exp_mask) && ((bits & man_mask) != '0);
    endfunction

    function automatic logic fp_mag_gt(input logic [FP_MAX_W-1:0] a,
                                       input logic [FP_MAX_W-1:0] b,
                                       input int w);
        logic [FP_MAX_W-1:0] mag_mask;
        mag_mask = (64'd1 << (w - 1)) - 64'd1;
        return (a & mag_mask) > (b & mag_mask);
    endfunction

endpackage

// File: rtl/fp_max_abs_reduce_if.sv
// Element stream in, per-frame max-magnitude result out.
// Latency: n/a (signal bundle).
// Backpressure: valid/ready on both the element and result sides.
interface fp_max_abs_reduce_if
    import fp_max_abs_reduce_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int IDX_W = DEF_IDX_W
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [W-1:0]     a;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     c;
    logic             max_sign;
    logic [IDX_W-1:0] max_idx;
    logic [IDX_W-1:0] count;
    logic             nan_seen;
    logic             cnt_ovf;

    modport master (
        output in_valid, in_last, a, out_ready,
        input  in_ready, out_valid, c, max_sign, max_idx, count, nan_seen, cnt_ovf
    );

    modport slave (
        input  in_valid, in_last, a, out_ready,
        output in_ready, out_valid, c, max_sign, max_idx, count, nan_seen, cnt_ovf
    );

endinterface

// File: rtl/fp_max_abs_reduce_mag_cmp.sv
// Magnitude compare of two floats plus NaN detect on the first operand.
// Latency: combinational.
// Backpressure: none.
module fp_mag_cmp
    import fp_max_abs_reduce_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    localparam int W    = 1 + EXP_W + MAN_W
)(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_gt_b,
    output logic         a_nan
);

    assign a_gt_b = fp_mag_gt(FP_MAX_W'(a), FP_MAX_W'(b), W);
    assign a_nan  = fp_is_nan(FP_MAX_W'(a), EXP_W, MAN_W);

endmodule

// File: rtl/fp_max_abs_reduce.sv
// Per-frame reduction to the largest-magnitude non-NaN element, with index/count/NaN/overflow.
// Latency: result registered 1 cycle after the accepted in_last.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result blocks new elements.
module fp_max_abs_reduce
    import fp_max_abs_reduce_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int IDX_W = DEF_IDX_W
)(
    input  logic                clk,
    input  logic                rstn,
    fp_max_abs_reduce_if.slave  bus
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [0:0]       S_EMPTY = 1'(ST_EMPTY);
    localparam logic [0:0]       S_ACCUM = 1'(ST_ACCUM);
    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [W-1:0]     max;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cnt;
        logic             have;
        logic             nan;
        logic             ovf;
    } run_t;

    logic [0:0]       state;
    run_t             run;
    run_t             run_nxt;
    logic             accept;
    logic             a_gt_max;
    logic             a_nan;
    logic [IDX_W-1:0] cnt_cur;
    logic             have_cur;

    fp_mag_cmp #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_mag_cmp (
        .a      (bus.a),
        .b      (run.max),
        .a_gt_b (a_gt_max),
        .a_nan  (a_nan)
    );

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // An empty frame never trusts leftover running fields.
    assign cnt_cur  = (state == S_EMPTY) ? '0 : run.cnt;
    assign have_cur = (state == S_ACCUM) && run.have;

    always_comb begin
        run_nxt      = run;
        run_nxt.cnt  = cnt_cur;
        run_nxt.have = have_cur || !a_nan;
        run_nxt.nan  = run.nan || a_nan;
        if (!a_nan && (!have_cur || a_gt_max)) begin
            run_nxt.max = bus.a;
            run_nxt.idx = cnt_cur;
        end
        if (cnt_cur == CNT_MAX) begin
            run_nxt.ovf = 1'b1;
        end else begin
            run_nxt.cnt = cnt_cur + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_EMPTY;
            run           <= '0;
            bus.out_valid <= 1'b0;
            bus.c         <= '0;
            bus.max_sign  <= 1'b0;
            bus.max_idx   <= '0;
            bus.count     <= '0;
            bus.nan_seen  <= 1'b0;
            bus.cnt_ovf   <= 1'b0;
        end else begin
            if (accept && bus.in_last) begin
                bus.out_valid <= 1'b1;
                bus.c         <= {1'b0, run_nxt.max[W-2:0]};
                bus.max_sign  <= run_nxt.max[W-1];
                bus.max_idx   <= run_nxt.idx;
                bus.count     <= run_nxt.cnt;
                bus.nan_seen  <= run_nxt.nan;
                bus.cnt_ovf   <= run_nxt.ovf;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (accept) begin
                if (bus.in_last) begin
                    state <= S_EMPTY;
                    run   <= '0;
                end else begin
                    state <= S_ACCUM;
                    run   <= run_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_max_abs_reduce.sv
// Drives two reducers (IDX_W=8 and IDX_W=2) with one element stream and scores both.
// Latency: expects results 1 cycle after the accepted last element.
// Backpressure: randomised out_ready; outputs must hold while stalled.
module tb_fp_max_abs_reduce;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_last;
    logic [15:0] a;
    logic        out_ready;
    logic        rand_on;

    always #5 clk = ~clk;

    fp_max_abs_reduce_if #(.EXP_W(5), .MAN_W(10), .IDX_W(8)) bus8 ();
    fp_max_abs_reduce_if #(.EXP_W(5), .MAN_W(10), .IDX_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_last   = in_last;
    assign bus8.a         = a;
    assign bus8.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_last   = in_last;
    assign bus2.a         = a;
    assign bus2.out_ready = out_ready;

    fp_max_abs_reduce #(.EXP_W(5), .MAN_W(10), .IDX_W(8)) dut8 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus8)
    );

    fp_max_abs_reduce #(.EXP_W(5), .MAN_W(10), .IDX_W(2)) dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: max magnitude over non-NaN elements, first position holding it.
    typedef struct {
        logic [15:0] c;
        logic        sgn;
        int          idx;
        int          n;
        logic        nan;
    } res_t;

    function automatic logic is_nan16(input logic [15:0] v);
        return (v[14:10] == 5'h1f) && (v[9:0] != 10'h0);
    endfunction

    function automatic int sat(input int v, input int k);
        int lim;
        lim = (1 << k) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic res_t model(input logic [15:0] q[$]);
        res_t r;
        int   best;
        logic found;
        best  = -1;
        found = 1'b0;
        r.n   = q.size();
        r.nan = 1'b0;
        r.c   = 16'h0;
        r.sgn = 1'b0;
        r.idx = 0;
        foreach (q[i]) begin
            if (is_nan16(q[i])) r.nan = 1'b1;
            else if (int'(q[i][14:0]) > best) best = int'(q[i][14:0]);
        end
        foreach (q[i]) begin
            if (!found && !is_nan16(q[i]) && int'(q[i][14:0]) == best) begin
                found = 1'b1;
                r.c   = {1'b0, q[i][14:0]};
                r.sgn = q[i][15];
                r.idx = i;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_elem();
        logic [15:0] v;
        int          k;
        v = 16'($urandom);
        k = $urandom_range(0, 7);
        case (k)
            0:       v = {v[15], 5'h1f, v[9:0] | 10'h1};
            1:       v = {v[15], 15'h7c00};
            2, 3:    v = {v[15], 3'b011, v[1:0], 10'h0};
            default: v = v;
        endcase
        return v;
    endfunction

    // Scoreboard / protocol monitor, sampling mid-cycle.
    logic [15:0] cur_q[$];
    res_t        exp_q[$];
    res_t        mon_e;
    logic        hold;
    logic [15:0] hold_c;
    logic        hold_s;
    logic [7:0]  hold_idx;
    logic [7:0]  hold_cnt;

    always @(negedge clk) begin
        if (!rstn) begin
            cur_q.delete();
            exp_q.delete();
            hold = 1'b0;
        end else begin
            check_val("vld_pending", 32'(bus8.out_valid), 32'(exp_q.size() != 0));
            check_val("rdy_rule", 32'(bus8.in_ready), 32'(!bus8.out_valid || out_ready));
            check_val("rdy_pair", 32'(bus2.in_ready), 32'(bus8.in_ready));
            if (hold) begin
                check_val("hold_vld", 32'(bus8.out_valid), 32'd1);
                check_val("hold_c", 32'(bus8.c), 32'(hold_c));
                check_val("hold_sign", 32'(bus8.max_sign), 32'(hold_s));
                check_val("hold_idx", 32'(bus8.max_idx), 32'(hold_idx));
                check_val("hold_cnt", 32'(bus8.count), 32'(hold_cnt));
            end
            if (bus8.out_valid && exp_q.size() != 0) begin
                mon_e = exp_q[0];
                check_val("sb_c", 32'(bus8.c), 32'(mon_e.c));
                check_val("sb_sign", 32'(bus8.max_sign), 32'(mon_e.sgn));
                check_val("sb_idx", 32'(bus8.max_idx), 32'(sat(mon_e.idx, 8)));
                check_val("sb_cnt", 32'(bus8.count), 32'(sat(mon_e.n, 8)));
                check_val("sb_nan", 32'(bus8.nan_seen), 32'(mon_e.nan));
                check_val("sb_ovf", 32'(bus8.cnt_ovf), 32'(mon_e.n > 255));
                check_val("sb2_vld", 32'(bus2.out_valid), 32'd1);
                check_val("sb2_c", 32'(bus2.c), 32'(mon_e.c));
                check_val("sb2_idx", 32'(bus2.max_idx), 32'(sat(mon_e.idx, 2)));
                check_val("sb2_cnt", 32'(bus2.count), 32'(sat(mon_e.n, 2)));
                check_val("sb2_ovf", 32'(bus2.cnt_ovf), 32'(mon_e.n > 3));
            end
            hold     = bus8.out_valid && !out_ready;
            hold_c   = bus8.c;
            hold_s   = bus8.max_sign;
            hold_idx = bus8.max_idx;
            hold_cnt = bus8.count;
            if (bus8.out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && bus8.in_ready) begin
                cur_q.push_back(a);
                if (in_last) begin
                    exp_q.push_back(model(cur_q));
                    cur_q.delete();
                end
            end
        end
    end

    task automatic send(input logic [15:0] v, input logic last);
        int budget;
        budget   = 200;
        a        = v;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!bus8.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_val("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] ec, input logic es,
                               input int eidx, input int ecnt, input logic enan,
                               input logic eovf, input int eidx2, input int ecnt2,
                               input logic eovf2);
        int b;
        b = 0;
        @(negedge clk);
        while (!bus8.out_valid && b < 50) begin
            @(negedge clk);
            b++;
        end
        check_val({tag, ".vld"}, 32'(bus8.out_valid), 32'd1);
        check_val({tag, ".lat"}, 32'(b), 32'd0);
        check_val({tag, ".c"}, 32'(bus8.c), 32'(ec));
        check_val({tag, ".sign"}, 32'(bus8.max_sign), 32'(es));
        check_val({tag, ".idx"}, 32'(bus8.max_idx), 32'(eidx));
        check_val({tag, ".cnt"}, 32'(bus8.count), 32'(ecnt));
        check_val({tag, ".nan"}, 32'(bus8.nan_seen), 32'(enan));
        check_val({tag, ".ovf"}, 32'(bus8.cnt_ovf), 32'(eovf));
        check_val({tag, ".idx2"}, 32'(bus2.max_idx), 32'(eidx2));
        check_val({tag, ".cnt2"}, 32'(bus2.count), 32'(ecnt2));
        check_val({tag, ".ovf2"}, 32'(bus2.cnt_ovf), 32'(eovf2));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        a         = 16'h0;
        out_ready = 1'b1;
        rand_on   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst.in_ready", 32'(bus8.in_ready), 32'd1);
        check_val("rst.vld", 32'(bus8.out_valid), 32'd0);
        check_val("rst.c", 32'(bus8.c), 32'd0);
        check_val("rst.sign", 32'(bus8.max_sign), 32'd0);
        check_val("rst.idx", 32'(bus8.max_idx), 32'd0);
        check_val("rst.cnt", 32'(bus8.count), 32'd0);
        check_val("rst.nan", 32'(bus8.nan_seen), 32'd0);
        check_val("rst.ovf", 32'(bus2.cnt_ovf), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        send(16'h3C00, 1'b0); send(16'hC400, 1'b0); send(16'h4000, 1'b1);
        wait_result("basic", 16'h4400, 1'b1, 1, 3, 1'b0, 1'b0, 1, 3, 1'b0);

        send(16'h4000, 1'b0); send(16'hC000, 1'b1);
        wait_result("tie", 16'h4000, 1'b0, 0, 2, 1'b0, 1'b0, 0, 2, 1'b0);

        send(16'h7E00, 1'b0); send(16'h3C00, 1'b0); send(16'h7C01, 1'b1);
        wait_result("nan_mix", 16'h3C00, 1'b0, 1, 3, 1'b1, 1'b0, 1, 3, 1'b0);

        send(16'h7E00, 1'b1);
        wait_result("all_nan", 16'h0000, 1'b0, 0, 1, 1'b1, 1'b0, 0, 1, 1'b0);

        send(16'hBC00, 1'b1);
        wait_result("single", 16'h3C00, 1'b1, 0, 1, 1'b0, 1'b0, 0, 1, 1'b0);

        send(16'hFC00, 1'b0); send(16'h7BFF, 1'b1);
        wait_result("inf", 16'h7C00, 1'b1, 0, 2, 1'b0, 1'b0, 0, 2, 1'b0);

        send(16'h3C00, 1'b0); send(16'h4000, 1'b0); send(16'h4400, 1'b0);
        send(16'h4800, 1'b0); send(16'h4C00, 1'b1);
        wait_result("ovf", 16'h4C00, 1'b0, 4, 5, 1'b0, 1'b0, 3, 3, 1'b1);

        // Stall the result while the next frame waits to stream in.
        out_ready = 1'b0;
        send(16'h3C00, 1'b0); send(16'h4000, 1'b0); send(16'h3800, 1'b1);
        a        = 16'h4400;
        in_last  = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("stall.in_ready", 32'(bus8.in_ready), 32'd0);
            check_val("stall.c", 32'(bus8.c), 32'h4000);
            check_val("stall.cnt", 32'(bus8.count), 32'd3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("both.in_ready", 32'(bus8.in_ready), 32'd1);
        check_val("both.vld", 32'(bus8.out_valid), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("both.vld_drop", 32'(bus8.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'h4800, 1'b1);
        wait_result("after_stall", 16'h4800, 1'b0, 1, 2, 1'b0, 1'b0, 1, 2, 1'b0);

        // Reset in the middle of a frame discards it.
        send(16'h5000, 1'b0); send(16'h5400, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("mrst.in_ready", 32'(bus8.in_ready), 32'd1);
        check_val("mrst.vld", 32'(bus8.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("mrst.no_vld", 32'(bus8.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h3C00, 1'b0); send(16'h3800, 1'b1);
        wait_result("post_rst", 16'h3C00, 1'b0, 0, 2, 1'b0, 1'b0, 0, 2, 1'b0);

        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int f = 0; f < 150; f++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) begin
                        send(rand_elem(), (i == len - 1));
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                rand_on = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_val("drain.queue", 32'(exp_q.size()), 32'd0);
        check_val("drain.vld", 32'(bus8.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
